// File: rtl/ctrl_frame_pkg.sv
// Shared types and defaults for the control-pulse frame synchroniser.
// Holds the FSM state encoding and the inter-pulse gap derivation.
package ctrl_frame_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int FRAME_LEN_DEF = 32;
    localparam int P0_DEF        = 4;
    localparam int P1_DEF        = 20;
    localparam int P2_DEF        = 24;
    localparam int ERR_CNT_W     = 8;
    localparam int GAP_W         = 6;

    // Gap preceding pulse idx: 0 -> P0 (wraps the frame), 1 -> P1, 2 -> P2.
    function automatic int pulse_gap(input int idx, input int frame_len,
                                     input int p0, input int p1, input int p2);
        case (idx)
            0:       return frame_len - p2 + p0;
            1:       return p1 - p0;
            default: return p2 - p1;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_gap_meter.sv
// Measures the spacing between control pulses while hunting and flags the
// pulse that follows the unique P2->P0 gap.
module ctrl_gap_meter
    import ctrl_frame_pkg::*;
#(
    parameter int SYNC_GAP = 12
) (
    input  logic clock,
    input  logic reset,
    input  logic pulse,
    input  logic clr,
    output logic gap_is_sync
);

    localparam logic [GAP_W-1:0] GAP_MAX  = '1;
    // The counter reads k-1 on the k-th cycle after a pulse.
    localparam logic [GAP_W-1:0] SYNC_CNT = GAP_W'(SYNC_GAP - 1);

    logic [GAP_W-1:0] gap;
    logic             seen;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            gap  <= '0;
            seen <= 1'b0;
        end else if (pulse) begin
            gap  <= '0;
            seen <= 1'b1;
        end else if (gap != GAP_MAX) begin
            gap  <= gap + 1'b1;
        end
    end

    assign gap_is_sync = pulse && seen && (gap == SYNC_CNT);

endmodule

// File: rtl/ctrl_frame_sync.sv
// Receive-side frame synchroniser: recovers frame phase from a single-wire
// pulse stream, confirms it over LOCK_FRAMES frames and tracks pulse errors.
module ctrl_frame_sync
    import ctrl_frame_pkg::*;
#(
    parameter int FRAME_LEN   = FRAME_LEN_DEF,
    parameter int CNT_W       = 5,
    parameter int P0          = P0_DEF,
    parameter int P1          = P1_DEF,
    parameter int P2          = P2_DEF,
    parameter int LOCK_FRAMES = 2,
    parameter int LOSS_FRAMES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_ctrl,
    output logic                 o_locked,
    output logic [CNT_W-1:0]     o_phase,
    output logic                 o_frame_start,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int G0 = pulse_gap(0, FRAME_LEN, P0, P1, P2);
    localparam int G1 = pulse_gap(1, FRAME_LEN, P0, P1, P2);
    localparam int G2 = pulse_gap(2, FRAME_LEN, P0, P1, P2);
    localparam int FRM_W = 8;

    localparam logic [CNT_W-1:0] PH_P0    = CNT_W'(P0);
    localparam logic [CNT_W-1:0] PH_P1    = CNT_W'(P1);
    localparam logic [CNT_W-1:0] PH_P2    = CNT_W'(P2);
    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] PH_ALIGN = CNT_W'((P0 + 1) % FRAME_LEN);
    localparam logic [FRM_W-1:0] LOCK_CNT = FRM_W'(LOCK_FRAMES);
    localparam logic [FRM_W-1:0] LOSS_CNT = FRM_W'(LOSS_FRAMES);

    // Alignment relies on the P2->P0 gap being unique within the frame.
    if (G0 == G1 || G0 == G2 || G1 == G2 || !(P0 < P1 && P1 < P2 && P2 < FRAME_LEN)
        || (1 << CNT_W) != FRAME_LEN) begin : g_bad_cfg
        $error("ctrl_frame_sync: invalid pulse phase configuration");
    end

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t               state, state_n;
    logic [CNT_W-1:0]     phase, phase_n;
    logic [FRM_W-1:0]     good_cnt, good_n;
    logic [FRM_W-1:0]     bad_cnt, bad_n;
    logic                 frame_bad, frame_bad_n;
    logic [ERR_CNT_W-1:0] err_cnt, err_cnt_n;
    logic                 frame_start_n;
    logic                 expected, mismatch, boundary;
    logic                 sync, gap_clr;

    ctrl_gap_meter #(
        .SYNC_GAP (G0)
    ) u_gap (
        .clock       (clock),
        .reset       (reset),
        .pulse       (i_ctrl),
        .clr         (gap_clr),
        .gap_is_sync (sync)
    );

    always_comb begin
        expected      = (phase == PH_P0) || (phase == PH_P1) || (phase == PH_P2);
        mismatch      = (state != HUNT) && (i_ctrl != expected);
        boundary      = (state != HUNT) && (phase == PH_LAST);
        state_n       = state;
        phase_n       = phase + 1'b1;
        good_n        = good_cnt;
        bad_n         = bad_cnt;
        frame_bad_n   = frame_bad | mismatch;
        err_cnt_n     = err_cnt;
        gap_clr       = 1'b0;
        case (state)
            HUNT: begin
                phase_n = '0;
                if (sync) begin
                    state_n     = CONFIRM;
                    phase_n     = PH_ALIGN;
                    good_n      = '0;
                    bad_n       = '0;
                    frame_bad_n = 1'b0;
                end
            end
            CONFIRM: begin
                if (mismatch) begin
                    state_n = HUNT;
                    phase_n = '0;
                    gap_clr = 1'b1;
                end else if (boundary) begin
                    good_n      = good_cnt + 1'b1;
                    frame_bad_n = 1'b0;
                    if ((good_cnt + 1'b1) >= LOCK_CNT) begin
                        state_n = LOCKED;
                        bad_n   = '0;
                    end
                end
            end
            LOCKED: begin
                if (mismatch) err_cnt_n = sat_inc(err_cnt);
                if (boundary) begin
                    frame_bad_n = 1'b0;
                    if (frame_bad || mismatch) begin
                        bad_n = bad_cnt + 1'b1;
                        if ((bad_cnt + 1'b1) >= LOSS_CNT) begin
                            state_n = HUNT;
                            phase_n = '0;
                            gap_clr = 1'b1;
                        end
                    end else begin
                        bad_n = '0;
                    end
                end
            end
            default: begin
                state_n = HUNT;
                phase_n = '0;
            end
        endcase
        frame_start_n = (state_n == LOCKED) && (phase_n == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= HUNT;
            phase         <= '0;
            good_cnt      <= '0;
            bad_cnt       <= '0;
            frame_bad     <= 1'b0;
            err_cnt       <= '0;
            o_err         <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            state         <= state_n;
            phase         <= phase_n;
            good_cnt      <= good_n;
            bad_cnt       <= bad_n;
            frame_bad     <= frame_bad_n;
            err_cnt       <= err_cnt_n;
            o_err         <= mismatch;
            o_frame_start <= frame_start_n;
        end
    end

    assign o_locked  = (state == LOCKED);
    assign o_phase   = phase;
    assign o_err_cnt = err_cnt;

endmodule
